// File: rtl/cond_branch_unit.sv
// NZVC flag register, branch-condition resolver and taken-branch counter for the ID stage.
// Build option FLAG_FWD_EN: forward live ALU flags to a B.cond instead of stalling one cycle.
//
// state | meaning
// IDLE  | branches resolve directly; a B.cond racing a flag write may stall
// WAIT  | held B.cond resolves from the freshly written flags_q
module cond_branch_unit #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_wr_en,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              br_req,
  input  logic [1:0]        br_type,
  input  logic [3:0]        br_cond,
  input  logic [DATA_W-1:0] cb_value,
  output logic              stall,
  output logic              br_valid,
  output logic              br_taken,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

`ifdef FLAG_FWD_EN
  localparam logic HAZARD = 1'b0;
`else
  localparam logic HAZARD = 1'b1;
`endif

  state_t             state_q, state_d;
  logic [3:0]         flags_d;
  logic               br_valid_q, br_valid_d;
  logic               br_taken_q, br_taken_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
  logic               accept;
  logic [3:0]         eval_flags;
  logic [3:0]         alu_flags;
  logic               fn, fz, fv, fc;
  logic               cond_hit;
  logic               resolution;

  assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    accept     = 1'b0;
    eval_flags = flags_q;
    case (state_q)
      IDLE: begin
        if (br_req && br_type == 2'b00 && flag_wr_en && HAZARD) begin
          stall   = 1'b1;
          state_d = WAIT;
        end else begin
          accept = br_req;
          if (flag_wr_en) eval_flags = alu_flags;
        end
      end
      WAIT: begin
        // A dropped request here is a protocol error: just fall back to IDLE.
        accept  = br_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  assign {fn, fz, fv, fc} = eval_flags;

  always_comb begin
    cond_hit = 1'b1;
    case (br_cond)
      4'b0000: cond_hit = fz;
      4'b0001: cond_hit = !fz;
      4'b0010: cond_hit = fc;
      4'b0011: cond_hit = !fc;
      4'b0100: cond_hit = fn;
      4'b0101: cond_hit = !fn;
      4'b0110: cond_hit = fv;
      4'b0111: cond_hit = !fv;
      4'b1000: cond_hit = fc && !fz;
      4'b1001: cond_hit = !(fc && !fz);
      4'b1010: cond_hit = (fn == fv);
      4'b1011: cond_hit = (fn != fv);
      4'b1100: cond_hit = !fz && (fn == fv);
      4'b1101: cond_hit = fz || (fn != fv);
      default: cond_hit = 1'b1;
    endcase
  end

  always_comb begin
    resolution = 1'b1;
    case (br_type)
      2'b00:   resolution = cond_hit;
      2'b01:   resolution = (cb_value == '0);
      2'b10:   resolution = (cb_value != '0);
      default: resolution = 1'b1;
    endcase
  end

  always_comb begin
    flags_d     = flag_wr_en ? alu_flags : flags_q;
    br_valid_d  = accept;
    br_taken_d  = accept ? resolution : br_taken_q;
    taken_cnt_d = taken_cnt_q;
    if (br_valid_q && br_taken_q && taken_cnt_q != {CNT_W{1'b1}})
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flags_q     <= 4'b0000;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_valid  = br_valid_q;
  assign br_taken  = br_taken_q;
  assign taken_cnt = taken_cnt_q;

endmodule
